// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit that formats store data, runs a req/ack data-bus
// access with an ack timeout, and extracts and extends load data for writeback.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] mem_data,
  output logic        stall,
  output logic        done,
  output logic        misalign_err,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          r_state;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic            r_load;
  logic [CW-1:0]   r_cnt;
  logic            w_access, w_misalign;
  logic [31:0]     w_wdata, w_shift, w_ext;
  logic [3:0]      w_wstrb;
  always_comb begin
    w_access   = valid_in & (is_load | is_store);
    // funct3 011/110/111 are illegal and reported as misaligned
    w_misalign = (funct3[1:0] == 2'b11) | (funct3[2] & funct3[1]) |
                 (funct3[0] & addr[0]) | (funct3[1] & (|addr[1:0]));
    w_wdata    = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    w_wstrb    = is_load ? 4'b0000 : funct3[1] ? 4'b1111 :
                 (funct3[0] ? 4'b0011 : 4'b0001) << addr[1:0];
    w_shift    = mem_rdata >> {r_off, 3'b000};
    w_ext      = r_f3[1] ? w_shift :
                 r_f3[0] ? {{16{w_shift[15] & ~r_f3[2]}}, w_shift[15:0]} :
                           {{24{w_shift[7] & ~r_f3[2]}}, w_shift[7:0]};
    stall      = (r_state == BUSY) | ((r_state == IDLE) & w_access & ~w_misalign);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_f3         <= '0;
      r_off        <= '0;
      r_load       <= 1'b0;
      r_cnt        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      mem_data     <= '0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      done         <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access & w_misalign) misalign_err <= 1'b1;
          else if (w_access) begin
            r_state   <= BUSY;
            r_f3      <= funct3;
            r_off     <= addr[1:0];
            r_load    <= is_load;
            mem_req   <= 1'b1;
            mem_we    <= ~is_load;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_wstrb <= w_wstrb;
          end
        end
        BUSY: begin
          // an ack arriving on the last allowed cycle still completes normally
          if (mem_ack | (r_cnt == CW'(TIMEOUT - 1))) begin
            r_state <= DONE;
            r_cnt   <= '0;
            mem_req <= 1'b0;
            done    <= 1'b1;
            bus_err <= ~mem_ack;
            if (r_load) mem_data <= mem_ack ? w_ext : 32'h0;
          end else r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven, hand-sequenced and randomized checks of mem_access_unit
// against expectations derived from the load/store rules.
module tb_mem_access_unit;
  localparam int TO = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid_in = 0, is_load = 0, is_store = 0, mem_ack = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata = 0;
  logic        mem_req, mem_we, stall, done, misalign_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_data;
  logic [3:0]  mem_wstrb;
  int          checks = 0, failures = 0;
  logic [31:0] m_data = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_data(mem_data), .stall(stall), .done(done),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, sd, rd;
    int          dly;
    logic        e_mis, e_to;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata, e_data;
  } vec_t;

  task automatic chk(input string nm, input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, got, exp);
    end
  endtask

  // Reference: expectations computed from byte sizes and plain arithmetic
  function automatic vec_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int dly);
    vec_t v;
    int nb, off;
    longint val;
    v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.dly = dly;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    v.e_mis = (f3 == 3'd3) || (f3 >= 3'd6) || (off % nb != 0);
    v.e_to = (dly < 0) || (dly >= TO);
    v.e_wstrb = (st && !ld) ? 4'(((1 << nb) - 1) << off) : 4'h0;
    for (int i = 0; i < 4; i++) v.e_wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
    val = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (!f3[2] && nb < 4 && val >= (longint'(1) << (8 * nb - 1))) val -= (longint'(1) << (8 * nb));
    v.e_data = (v.e_mis || !ld) ? m_data : v.e_to ? 32'h0 : val[31:0];
    return v;
  endfunction

  // Entered and left at posedge+1 with the DUT idle
  task automatic run_access(input vec_t v, input string nm);
    logic hold_ok, seen, we_exp;
    int n;
    we_exp = v.st & ~v.ld;
    valid_in = 1; is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.a; store_data = v.sd;
    #1;
    chk(nm, "stall_accept", stall, !v.e_mis);
    chk(nm, "req_accept", mem_req, 0);
    @(posedge clk); #1;
    if (v.e_mis) begin
      chk(nm, "misalign_err", misalign_err, 1);
      chk(nm, "mis_req", mem_req, 0);
      chk(nm, "mis_stall", stall, 0);
      chk(nm, "mis_data", mem_data, v.e_data);
      valid_in = 0;
      @(posedge clk); #1;
      chk(nm, "mis_pulse", misalign_err, 0);
      chk(nm, "mis_no_req", mem_req, 0);
    end else begin
      chk(nm, "addr", mem_addr, {v.a[31:2], 2'b00});
      chk(nm, "we", mem_we, we_exp);
      chk(nm, "wstrb", mem_wstrb, v.e_wstrb);
      if (we_exp) chk(nm, "wdata", mem_wdata, v.e_wdata);
      n = 0; hold_ok = 1; seen = 0;
      while (!seen && n < TO + 4) begin
        if (mem_req !== 1'b1 || stall !== 1'b1 || mem_we !== we_exp ||
            mem_addr !== {v.a[31:2], 2'b00} || mem_wstrb !== v.e_wstrb) hold_ok = 0;
        mem_ack = (n == v.dly);
        mem_rdata = (n == v.dly) ? v.rd : $urandom;
        @(posedge clk); #1;
        mem_ack = 0;
        n++;
        seen = done;
      end
      chk(nm, "busy_hold", hold_ok, 1);
      chk(nm, "done_seen", seen, 1);
      chk(nm, "busy_cycles", 32'(n), v.e_to ? 32'(TO) : 32'(v.dly + 1));
      chk(nm, "done_stall", stall, 0);
      chk(nm, "done_req", mem_req, 0);
      chk(nm, "bus_err", bus_err, v.e_to);
      chk(nm, "data", mem_data, v.e_data);
      valid_in = 0;
      @(posedge clk); #1;
      chk(nm, "done_pulse", done, 0);
      chk(nm, "bus_err_pulse", bus_err, 0);
    end
    m_data = v.e_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[17];
    vec_t v;
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    int dly;
    tbl[0]  = '{1, 0, 3'd0, 32'h1003, 32'h0,         32'h80FF1234, 2,  0, 0, 4'h0, 32'h0,         32'hFFFFFF80};
    tbl[1]  = '{1, 0, 3'd5, 32'h2002, 32'h0,         32'hBEEF0000, 0,  0, 0, 4'h0, 32'h0,         32'h0000BEEF};
    tbl[2]  = '{0, 1, 3'd0, 32'h0013, 32'h123456AB,  32'h0,        1,  0, 0, 4'h8, 32'hABABABAB,  32'h0000BEEF};
    tbl[3]  = '{0, 1, 3'd1, 32'h0012, 32'h0000CAFE,  32'h0,        0,  0, 0, 4'hC, 32'hCAFECAFE,  32'h0000BEEF};
    tbl[4]  = '{1, 0, 3'd2, 32'h0006, 32'h0,         32'h0,        0,  1, 0, 4'h0, 32'h0,         32'h0000BEEF};
    tbl[5]  = '{1, 0, 3'd3, 32'h0008, 32'h0,         32'h0,        0,  1, 0, 4'h0, 32'h0,         32'h0000BEEF};
    tbl[6]  = '{1, 0, 3'd2, 32'h0040, 32'h0,         32'hDEADBEEF, 1,  0, 0, 4'h0, 32'h0,         32'hDEADBEEF};
    tbl[7]  = '{1, 0, 3'd1, 32'h0042, 32'h0,         32'h80010000, 3,  0, 0, 4'h0, 32'h0,         32'hFFFF8001};
    tbl[8]  = '{1, 0, 3'd4, 32'h0041, 32'h0,         32'h00009A00, 0,  0, 0, 4'h0, 32'h0,         32'h0000009A};
    tbl[9]  = '{0, 1, 3'd2, 32'h0044, 32'hCAFEF00D,  32'h0,        2,  0, 0, 4'hF, 32'hCAFEF00D,  32'h0000009A};
    tbl[10] = '{1, 0, 3'd1, 32'h0043, 32'h0,         32'h0,        0,  1, 0, 4'h0, 32'h0,         32'h0000009A};
    tbl[11] = '{1, 0, 3'd2, 32'h0050, 32'h0,         32'h12345678, -1, 0, 1, 4'h0, 32'h0,         32'h00000000};
    tbl[12] = '{1, 0, 3'd2, 32'h0054, 32'h0,         32'h11223344, 15, 0, 0, 4'h0, 32'h0,         32'h11223344};
    tbl[13] = '{1, 1, 3'd2, 32'h0060, 32'h99999999,  32'h55AA55AA, 0,  0, 0, 4'h0, 32'h0,         32'h55AA55AA};
    tbl[14] = '{0, 1, 3'd6, 32'h0070, 32'h0,         32'h0,        0,  1, 0, 4'h0, 32'h0,         32'h55AA55AA};
    tbl[15] = '{0, 1, 3'd0, 32'h0021, 32'h000000C3,  32'h0,        0,  0, 0, 4'h2, 32'hC3C3C3C3,  32'h55AA55AA};
    tbl[16] = '{1, 0, 3'd0, 32'h0032, 32'h0,         32'h007F0000, 1,  0, 0, 4'h0, 32'h0,         32'h0000007F};

    #2;
    chk("reset", "req", mem_req, 0);
    chk("reset", "we", mem_we, 0);
    chk("reset", "pulses", {done, misalign_err, bus_err}, 0);
    chk("reset", "data", mem_data, 0);
    chk("reset", "addr", mem_addr, 0);
    chk("reset", "wdata", mem_wdata, 0);
    chk("reset", "wstrb", mem_wstrb, 0);
    chk("reset", "stall", stall, 0);
    #10 rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      run_access(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].e_to) begin
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("late_ack", "data", mem_data, m_data);
        chk("late_ack", "done", done, 0);
        chk("late_ack", "req", mem_req, 0);
        chk("late_ack", "bus_err", bus_err, 0);
      end
    end

    valid_in = 1; is_load = 0; is_store = 0; funct3 = 3'd2; addr = 32'h100;
    #1;
    chk("nonaccess", "stall", stall, 0);
    @(posedge clk); #1;
    chk("nonaccess", "req", mem_req, 0);
    chk("nonaccess", "pulses", {done, misalign_err, bus_err}, 0);
    valid_in = 0;

    is_load = 1; funct3 = 3'd2; addr = 32'h80; valid_in = 1;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_busy", "req_before", mem_req, 1);
    rst = 1; valid_in = 0;
    #1;
    chk("rst_busy", "req", mem_req, 0);
    chk("rst_busy", "pulses", {done, misalign_err, bus_err}, 0);
    chk("rst_busy", "stall", stall, 0);
    chk("rst_busy", "data", mem_data, 0);
    m_data = 0;
    #2 rst = 0;
    @(posedge clk); #1;
    run_access(model(1, 0, 3'd2, 32'h84, 32'h0, 32'h0BADF00D, 1), "post_rst");

    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom % 2);
      st = ld ? ($urandom % 4 == 0) : 1'b1;
      f3 = 3'($urandom % 8);
      if (!ld && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = 2'b00;
      dly = ($urandom % 8 == 0) ? TO + 2 : int'($urandom % 5);
      run_access(model(ld, st, f3, a, $urandom, $urandom, dly), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
